// File: rtl/rf_pkg.sv
// Shared register-file types: architectural widths and the queued write entry.
package rf_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] wn;
    logic [DATA_W-1:0] d;
  } rf_entry_t;

  // r0 is hardwired to zero, so it never carries a write or a hazard.
  function automatic logic is_arch_reg(input logic [REG_AW-1:0] wn);
    return wn != ZERO_REG;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Queue of long-latency results waiting for the register-file write port.
// Live bits are per-entry control state and can be cleared by an external kill mask.
module rf_wr_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  rf_entry_t                     push_entry,
  input  logic                          pop,
  input  logic [DEPTH-1:0]              kill,
  output rf_entry_t                     head,
  output logic [DEPTH-1:0]              live_vec,
  output logic [DEPTH-1:0][REG_AW-1:0]  wn_vec,
  output logic [AW:0]                   count
);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DEPTH-1:0]  live_q;
  logic [DEPTH-1:0]  live_next;
  logic [REG_AW-1:0] wn_mem [DEPTH];
  logic [DATA_W-1:0] d_mem  [DEPTH];

  // Popped slots are cleared so live_q alone marks pending writes; no occupancy mask needed.
  always_comb begin
    live_next = live_q & ~kill;
    if (pop)  live_next[rd_ptr] = 1'b0;
    if (push) live_next[wr_ptr] = push_entry.live;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      live_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      live_q <= live_next;
    end
  end

  // Payload storage carries no reset; live_q decides whether it matters.
  always_ff @(posedge clk) begin
    if (push) begin
      wn_mem[wr_ptr] <= push_entry.wn;
      d_mem[wr_ptr]  <= push_entry.d;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wn_vec[i] = wn_mem[i];
    end
  end

  assign live_vec = live_q;
  assign head = '{live: live_q[rd_ptr], wn: wn_mem[rd_ptr], d: d_mem[rd_ptr]};

endmodule

// File: rtl/rf_wr_arb.sv
// Write-port arbiter: WB always wins, queued long-latency results fill idle cycles,
// later WB writes squash older queued writes to the same register.
module rf_wr_arb
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_wn,
  input  logic [DATA_W-1:0] wb_d,
  input  logic              lt_valid,
  output logic              lt_ready,
  input  logic [REG_AW-1:0] lt_wn,
  input  logic [DATA_W-1:0] lt_d,
  input  logic [REG_AW-1:0] rna_q,
  input  logic [REG_AW-1:0] rnb_q,
  output logic              hz_a,
  output logic              hz_b,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wn,
  output logic [DATA_W-1:0] rf_d,
  output logic              stall_o,
  output logic [AW:0]       count
);

  localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 1);

  logic                         wb_write;
  logic                         head_valid;
  logic                         push;
  logic                         pop;
  rf_entry_t                    push_entry;
  rf_entry_t                    head;
  logic [DEPTH-1:0]             live_vec;
  logic [DEPTH-1:0]             kill;
  logic [DEPTH-1:0][REG_AW-1:0] wn_vec;

  function automatic logic pending_write(input logic [DEPTH-1:0]             live,
                                         input logic [DEPTH-1:0][REG_AW-1:0] wns,
                                         input logic [REG_AW-1:0]            rn);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && wns[i] == rn) hit = 1'b1;
    end
    return is_arch_reg(rn) & hit;
  endfunction

  assign wb_write   = wb_we & is_arch_reg(wb_wn);
  assign head_valid = (count != '0);
  assign lt_ready   = rst & (count != FULL_CNT);
  assign push       = lt_valid & lt_ready;
  assign stall_o    = (count >= STALL_CNT);

  // A result arriving alongside a WB write to the same register is already stale.
  assign push_entry = '{live: is_arch_reg(lt_wn) & ~(wb_write & (wb_wn == lt_wn)),
                        wn:   lt_wn,
                        d:    lt_d};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      kill[i] = wb_write & (wn_vec[i] == wb_wn);
    end
  end

  // A dead head drains even while WB owns the port; a live head waits for a free cycle.
  assign pop = head_valid & (~head.live | ~wb_write);

  assign rf_we = rst & (wb_write | (head_valid & head.live));
  assign rf_wn = wb_write ? wb_wn : head.wn;
  assign rf_d  = wb_write ? wb_d  : head.d;

  assign hz_a = pending_write(live_vec, wn_vec, rna_q);
  assign hz_b = pending_write(live_vec, wn_vec, rnb_q);

  rf_wr_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .kill       (kill),
    .head       (head),
    .live_vec   (live_vec),
    .wn_vec     (wn_vec),
    .count      (count)
  );

endmodule
